// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register file write port between two writeback sources,
// with a registered write launch and read bypass from the in-flight write.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [CNT_W-1:0]  grant_count
);
    logic              last;
    logic              grant;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    // last==1 means requester 1 was served most recently, so requester 0 wins a tie
    always_comb begin
        req0_ready = req0_valid && (!req1_valid || last);
        req1_ready = req1_valid && (!req0_valid || !last);
        grant      = req0_ready || req1_ready;
        win_addr   = req1_ready ? req1_addr : req0_addr;
        win_data   = req1_ready ? req1_data : req0_data;
        rd_data1   = (rf_we && rf_waddr == rd_addr1) ? rf_wdata : rf_rdata1;
        rd_data2   = (rf_we && rf_waddr == rd_addr2) ? rf_wdata : rf_rdata2;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last        <= 1'b1;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            grant_count <= '0;
        end else begin
            rf_we <= grant && win_addr != '0;
            if (grant) begin
                last     <= req1_ready;
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
                if (grant_count != '1)
                    grant_count <= grant_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed plus randomized checks against a behavioural model of the arbiter.
module tb_regfile_write_arbiter;
    localparam int DW = 32, AW = 5, CW = 4;
    logic clk = 0, rst_n = 0;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready, rf_we;
    logic [AW-1:0] req0_addr = 0, req1_addr = 0, rf_waddr, rd_addr1 = 0, rd_addr2 = 0;
    logic [DW-1:0] req0_data = 0, req1_data = 0, rf_wdata, rf_rdata1 = 0, rf_rdata2 = 0, rd_data1, rd_data2;
    logic [CW-1:0] grant_count;
    int vectors = 0, miscompares = 0;
    int m_last = 1, m_we = 0, m_addr = 0, m_cnt = 0;
    logic [DW-1:0] m_data = 0;
    int g;
    logic p0v = 0, p1v = 0;
    logic [AW-1:0] p0a = 0, p1a = 0;
    logic [DW-1:0] p0d = 0, p1d = 0;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] bypass(input logic [AW-1:0] ra, input logic [DW-1:0] raw);
        return (m_we != 0 && m_addr == int'(ra)) ? m_data : raw;
    endfunction

    // One clock: apply requests, check handshake and bypass, then check the launched write.
    // Entry and exit are 1 time unit after a rising edge. gnt returns -1, 0 or 1.
    task automatic cycle(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         output int gnt);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rd_addr1 = ($urandom_range(1) != 0) ? AW'(m_addr) : AW'($urandom);
        rd_addr2 = ($urandom_range(1) != 0) ? AW'(m_addr) : AW'($urandom);
        rf_rdata1 = $urandom; rf_rdata2 = $urandom;
        gnt = (v0 && v1) ? 1 - m_last : v0 ? 0 : v1 ? 1 : -1;
        #1;
        chk("req0_ready", DW'(req0_ready), DW'(gnt == 0));
        chk("req1_ready", DW'(req1_ready), DW'(gnt == 1));
        chk("rd_data1", rd_data1, bypass(rd_addr1, rf_rdata1));
        chk("rd_data2", rd_data2, bypass(rd_addr2, rf_rdata2));
        @(posedge clk);
        if (gnt >= 0) begin
            m_last = gnt;
            m_addr = (gnt == 1) ? int'(a1) : int'(a0);
            m_data = (gnt == 1) ? d1 : d0;
            m_we = (m_addr != 0) ? 1 : 0;
            m_cnt = (m_cnt < 2**CW - 1) ? m_cnt + 1 : m_cnt;
        end else m_we = 0;
        #1;
        chk("rf_we", DW'(rf_we), DW'(m_we));
        chk("rf_waddr", DW'(rf_waddr), DW'(m_addr));
        chk("rf_wdata", rf_wdata, m_data);
        chk("grant_count", DW'(grant_count), DW'(m_cnt));
    endtask

    initial begin
        rf_rdata1 = 32'h5555_5555;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", DW'(rf_we), 0);
        chk("reset_ready0", DW'(req0_ready), 0);
        chk("reset_ready1", DW'(req1_ready), 0);
        chk("reset_count", DW'(grant_count), 0);
        chk("reset_rd1", rd_data1, 32'h5555_5555);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        // contention from reset: strict alternation starting with requester 0
        for (int i = 0; i < 4; i++) begin
            cycle(1, 3, 32'h300 + i, 1, 4, 32'h400 + i, g);
            chk("contend_order", DW'(rf_waddr), (i % 2 == 0) ? 3 : 4);
        end
        chk("contend_count", DW'(grant_count), 4);
        cycle(1, 5, 32'hDEAD_BEEF, 0, 0, 0, g);
        chk("single_waddr", DW'(rf_waddr), 5);
        chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);
        cycle(0, 0, 0, 1, 0, 32'h1234, g);
        chk("zero_we", DW'(rf_we), 0);
        chk("zero_count", DW'(grant_count), 6);
        cycle(1, 7, 32'hA5A5_A5A5, 0, 0, 0, g);
        rd_addr1 = 7; rf_rdata1 = 0; #1;
        chk("bypass_hit", rd_data1, 32'hA5A5_A5A5);
        rd_addr1 = 8; rf_rdata1 = 32'h0BAD_F00D; #1;
        chk("bypass_miss", rd_data1, 32'h0BAD_F00D);
        // randomized traffic; losers keep their request stable until granted
        for (int i = 0; i < 300; i++) begin
            if (!p0v || g == 0) begin p0v = $urandom_range(3) != 0; p0a = AW'($urandom); p0d = $urandom; end
            if (!p1v || g == 1) begin p1v = $urandom_range(3) != 0; p1a = AW'($urandom); p1d = $urandom; end
            cycle(p0v, p0a, p0d, p1v, p1a, p1d, g);
        end
        chk("saturated", DW'(grant_count), 2**CW - 1);
        // asynchronous reset between edges with a write in flight
        cycle(0, 0, 0, 1, 9, 32'h9999, g);
        chk("pre_reset_we", DW'(rf_we), 1);
        rst_n = 0; #1;
        chk("async_we", DW'(rf_we), 0);
        chk("async_count", DW'(grant_count), 0);
        chk("async_waddr", DW'(rf_waddr), 0);
        m_last = 1; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        cycle(1, 10, 32'hAAAA, 1, 11, 32'hBBBB, g);
        chk("post_reset_first", DW'(g), 0);
        cycle(1, 10, 32'hAAAA, 1, 11, 32'hBBBB, g);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
